// File: rtl/coeff_token_enc.sv
`default_nettype none
// ============================================================================
//  Module      : coeff_token_enc
//  Description : CAVLC coeff_token encoder for H.264 4x4 blocks.
//                Stage 1 derives nC from the neighbour TotalCoeff values and
//                picks the VLC table. Stage 2 looks up the codeword. Both
//                stages sit in a valid/ready pipeline with full throughput.
//                A running count of emitted bits supports rate control.
//  Ports       : clk, rst             - clock, synchronous active-high reset
//                in_valid_i/in_ready_o - request handshake
//                total_coeff_i, trailing_ones_i, nA_i, nB_i, avail_a_i,
//                avail_b_i, chroma_dc_i - per-block request fields
//                out_valid_o/out_ready_i - result handshake
//                code_o, len_o, err_o  - codeword (right-aligned), length,
//                                        illegal-input flag
//                bitcnt_clr_i, bitcnt_o - emitted-bit accumulator
//  Revision    : 1.0 - initial release
// ============================================================================
module coeff_token_enc #(
    parameter int CODE_W       = 16,
    parameter int LEN_W        = 5,
    parameter int CHROMA_DC_EN = 1,
    parameter int BITCNT_W     = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [4:0]          total_coeff_i,
    input  logic [1:0]          trailing_ones_i,
    input  logic [4:0]          nA_i,
    input  logic [4:0]          nB_i,
    input  logic                avail_a_i,
    input  logic                avail_b_i,
    input  logic                chroma_dc_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [CODE_W-1:0]   code_o,
    output logic [LEN_W-1:0]    len_o,
    output logic                err_o,
    input  logic                bitcnt_clr_i,
    output logic [BITCNT_W-1:0] bitcnt_o
);

    // Table select encoding
    localparam logic [2:0] C_SEL_T0  = 3'd0;  // 0 <= nC < 2
    localparam logic [2:0] C_SEL_T1  = 3'd1;  // 2 <= nC < 4
    localparam logic [2:0] C_SEL_T2  = 3'd2;  // 4 <= nC < 8
    localparam logic [2:0] C_SEL_FLC = 3'd3;  // nC >= 8, 6-bit fixed length
    localparam logic [2:0] C_SEL_CD  = 3'd4;  // chroma DC, nC = -1

    // VLC tables. One nibble per (TotalCoeff, TrailingOnes) entry, entry
    // index TC*4+T1, entry 0 in the most significant nibble; groups of four
    // nibbles are one TotalCoeff row (T1 = 0..3 left to right).
    // *_LEN holds (length - 1), *_VAL holds the codeword value. Every VLC
    // codeword value fits in 4 bits; entries with T1 > TC are unused.
    localparam logic [271:0] C_T0_LEN = 272'h0000_5100_7520_8764_9875_a986_ca97_cca8_ccc9_ddca_dddc_eedd_eeed_feee_fffe_ffff_ffff;
    localparam logic [271:0] C_T0_VAL = 272'h1000_5100_7410_7653_7653_7654_f654_be54_8ad4_fe94_badc_fe9c_bad8_f19c_bed8_7a9c_4658;
    localparam logic [271:0] C_T1_LEN = 272'h1000_5100_5420_6553_7553_7664_8775_a885_aaa6_baa8_bbba_bbba_cccb_cccc_cdcc_dddc_dddd;
    localparam logic [271:0] C_T1_VAL = 272'h3000_b200_7730_7a95_7654_4656_7658_f654_bed4_fa94_bedc_8a98_fedc_ba9c_7b68_98a1_7654;
    localparam logic [271:0] C_T2_LEN = 272'h3000_5300_5430_5443_6443_6443_6553_6553_7664_7765_8776_8877_8887_9888_9999_9999_9999;
    localparam logic [271:0] C_T2_VAL = 272'hf000_fe00_bfd0_8cec_fabb_b89a_9ed9_8a98_fedd_beac_fadc_be9c_8ad8_d79c_9cba_5876_1432;
    // Chroma DC only has TC = 0..4; padded to the common width so the same
    // index arithmetic serves every table.
    localparam logic [271:0] C_CD_LEN = {80'h1000_5000_5520_5665_5776, 192'h0};
    localparam logic [271:0] C_CD_VAL = {80'h1000_7100_4610_3325_2320, 192'h0};

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic              r_s1_valid;
    logic [4:0]        r_s1_tc;
    logic [1:0]        r_s1_t1;
    logic [2:0]        r_s1_sel;

    logic              r_out_valid;
    logic [CODE_W-1:0] r_code;
    logic [LEN_W-1:0]  r_len;
    logic              r_err;
    logic [BITCNT_W-1:0] r_bitcnt;

    logic w_advance;
    logic w_in_ready;
    logic w_accept;

    assign w_advance  = !r_out_valid || out_ready_i;
    assign w_in_ready = !r_s1_valid || w_advance;
    assign w_accept   = in_valid_i && w_in_ready;

    // ------------------------------------------------------------------
    // Stage 1: nC and table select
    // ------------------------------------------------------------------
    logic       w_chroma;
    logic [5:0] w_nc_both;
    logic [5:0] w_nc;
    logic [2:0] w_sel;

    assign w_chroma  = (CHROMA_DC_EN != 0) && chroma_dc_i;
    // Six bits keep nA+nB+1 (up to 63) from overflowing before the halving.
    assign w_nc_both = ({1'b0, nA_i} + {1'b0, nB_i} + 6'd1) >> 1;

    always_comb begin
        w_nc = 6'd0;
        if (avail_a_i && avail_b_i) begin
            w_nc = w_nc_both;
        end else if (avail_a_i) begin
            w_nc = {1'b0, nA_i};
        end else if (avail_b_i) begin
            w_nc = {1'b0, nB_i};
        end
    end

    always_comb begin
        w_sel = C_SEL_FLC;
        if (w_chroma) begin
            w_sel = C_SEL_CD;
        end else if (w_nc < 6'd2) begin
            w_sel = C_SEL_T0;
        end else if (w_nc < 6'd4) begin
            w_sel = C_SEL_T1;
        end else if (w_nc < 6'd8) begin
            w_sel = C_SEL_T2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_tc    <= 5'd0;
            r_s1_t1    <= 2'd0;
            r_s1_sel   <= C_SEL_T0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_tc    <= total_coeff_i;
            r_s1_t1    <= trailing_ones_i;
            r_s1_sel   <= w_sel;
        end else if (w_advance) begin
            r_s1_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: legality check and table lookup
    // ------------------------------------------------------------------
    logic       w_tc_gt16;
    logic       w_err;
    logic [6:0] w_idx;
    logic [8:0] w_sh;
    logic [3:0] w_nib_len;
    logic [3:0] w_nib_val;
    logic [3:0] w_tcm1;
    logic [5:0] w_flc_val;
    logic [4:0] w_len5;
    logic [5:0] w_val6;

    assign w_tc_gt16 = r_s1_tc > 5'd16;
    assign w_err     = ({3'b000, r_s1_t1} > r_s1_tc) || w_tc_gt16 ||
                       ((r_s1_sel == C_SEL_CD) && (r_s1_tc > 5'd4));

    // Out-of-range TC is forced to entry 0 so the select stays in bounds;
    // the result is discarded by the error path anyway.
    assign w_idx = w_tc_gt16 ? 7'd0 : {r_s1_tc, r_s1_t1};
    assign w_sh  = 9'd268 - {w_idx, 2'b00};

    always_comb begin
        w_nib_len = 4'd0;
        w_nib_val = 4'd0;
        case (r_s1_sel)
            C_SEL_T0: begin
                w_nib_len = C_T0_LEN[w_sh +: 4];
                w_nib_val = C_T0_VAL[w_sh +: 4];
            end
            C_SEL_T1: begin
                w_nib_len = C_T1_LEN[w_sh +: 4];
                w_nib_val = C_T1_VAL[w_sh +: 4];
            end
            C_SEL_T2: begin
                w_nib_len = C_T2_LEN[w_sh +: 4];
                w_nib_val = C_T2_VAL[w_sh +: 4];
            end
            C_SEL_CD: begin
                w_nib_len = C_CD_LEN[w_sh +: 4];
                w_nib_val = C_CD_VAL[w_sh +: 4];
            end
            default: ;
        endcase
    end

    // FLC: TC=0 has its own codeword, otherwise {TC-1, T1}. TC=16 wraps
    // cleanly to 4'hF in the 4-bit subtraction.
    assign w_tcm1    = r_s1_tc[3:0] - 4'd1;
    assign w_flc_val = (r_s1_tc == 5'd0) ? 6'b000011 : {w_tcm1, r_s1_t1};

    always_comb begin
        w_len5 = 5'd0;
        w_val6 = 6'd0;
        if (!w_err) begin
            if (r_s1_sel == C_SEL_FLC) begin
                w_len5 = 5'd6;
                w_val6 = w_flc_val;
            end else begin
                w_len5 = {1'b0, w_nib_len} + 5'd1;
                w_val6 = {2'b00, w_nib_val};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_code      <= '0;
            r_len       <= '0;
            r_err       <= 1'b0;
        end else if (w_advance) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_code <= CODE_W'(w_val6);
                r_len  <= LEN_W'(w_len5);
                r_err  <= w_err;
            end
        end
    end

    // ------------------------------------------------------------------
    // Emitted-bit accumulator; clear wins over a coincident handshake.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || bitcnt_clr_i) begin
            r_bitcnt <= '0;
        end else if (r_out_valid && out_ready_i) begin
            r_bitcnt <= r_bitcnt + BITCNT_W'(r_len);
        end
    end

    assign in_ready_o  = w_in_ready;
    assign out_valid_o = r_out_valid;
    assign code_o      = r_code;
    assign len_o       = r_len;
    assign err_o       = r_err;
    assign bitcnt_o    = r_bitcnt;

endmodule
`default_nettype wire
